// File: rtl/led_pkg.sv
// Shared constants for the LED matrix scan driver: register offsets, CTRL
// bit positions and the scan FSM state type.
package led_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_SCAN_DIV = 1;
  localparam int unsigned REG_STATUS   = 2;
  localparam int unsigned REG_ROW_BASE = 4;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_BLINK      = 1;
  localparam int unsigned CTRL_BRIGHT_LSB = 8;

  localparam int unsigned STATUS_PWM_LSB   = 8;
  localparam int unsigned STATUS_FRAME_LSB = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/led_scan_timer.sv
// Scan timing core: prescaler, PWM slot counter, row counter and frame
// counter, plus the scan FSM that parks everything while disabled.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned ROW_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [DIV_W-1:0]    scan_div_i,
  output logic                active_o,
  output logic [ROW_W-1:0]    row_idx_o,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic [15:0]         frame_cnt_o,
  output logic                frame_o
);

  scan_state_e         state_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [ROW_W-1:0]    row_idx_q;
  logic [15:0]         frame_cnt_q;
  logic                frame_q;

  logic run;
  logic tick;
  logic pwm_wrap;
  logic row_wrap;

  // en_i is the enable value being committed this edge, so a disabling write
  // parks the counters on the same edge instead of one cycle later.
  assign run      = (state_q == ST_SCAN) && en_i;
  assign tick     = run && (div_cnt_q == '0);
  assign pwm_wrap = &pwm_cnt_q;
  assign row_wrap = (row_idx_q == ROW_W'(ROWS - 1));

  // NOTE: every register in a clocked block is assigned with <=, so all of
  // them sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      row_idx_q   <= '0;
      frame_cnt_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          div_cnt_q <= scan_div_i;
          pwm_cnt_q <= '0;
          row_idx_q <= '0;
          if (en_i) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!en_i) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= scan_div_i;
            pwm_cnt_q <= '0;
            row_idx_q <= '0;
          end else if (tick) begin
            div_cnt_q <= scan_div_i;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (pwm_wrap) begin
              row_idx_q <= row_wrap ? '0 : row_idx_q + ROW_W'(1);
              if (row_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                frame_q     <= 1'b1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q - DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign active_o    = run;
  assign row_idx_o   = row_idx_q;
  assign pwm_cnt_o   = pwm_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
  assign frame_o     = frame_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Memory-mapped row-multiplexed LED matrix driver: register file, read mux
// and registered row/column output stage around the scan timer.
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLINK_BIT = 5,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       write_data,
  input  logic              write_en,
  output logic [31:0]       read_data,
  output logic [ROWS-1:0]   row_sel_o,
  output logic [COLS-1:0]   col_o,
  output logic              frame_o
);

  localparam int unsigned ROW_W = $clog2(ROWS);

  logic                en_q, en_d;
  logic                blink_q, blink_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [COLS-1:0]     row_q [ROWS];
  logic [COLS-1:0]     row_d [ROWS];

  logic [ROWS-1:0]     row_sel_q, row_sel_d;
  logic [COLS-1:0]     col_q, col_d;
  logic                lit;

  logic                active;
  logic [ROW_W-1:0]    row_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         frame_cnt;

  // Not every write_data bit lands in a register; fold them so that is explicit.
  logic unused_wdata;
  assign unused_wdata = ^write_data;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input int unsigned off);
    return a == ADDR_W'(off);
  endfunction

  // NOTE: every next-state value starts as a copy of its register, so paths
  // without a write keep state and no latch is inferred.
  always_comb begin
    en_d     = en_q;
    blink_d  = blink_q;
    bright_d = bright_q;
    div_d    = div_q;
    row_d    = row_q;
    if (write_en) begin
      if (hit(addr_i, REG_CTRL)) begin
        en_d     = write_data[CTRL_EN];
        blink_d  = write_data[CTRL_BLINK];
        bright_d = write_data[CTRL_BRIGHT_LSB +: PWM_BITS];
      end
      if (hit(addr_i, REG_SCAN_DIV)) div_d = write_data[DIV_W-1:0];
      for (int unsigned n = 0; n < ROWS; n++) begin
        if (hit(addr_i, REG_ROW_BASE + n)) row_d[n] = write_data[COLS-1:0];
      end
    end
  end

  // NOTE: the row patterns are a small flop array rather than a RAM, so they
  // take the asynchronous reset like every other register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      blink_q  <= 1'b0;
      bright_q <= '0;
      div_q    <= '0;
      for (int unsigned n = 0; n < ROWS; n++) row_q[n] <= '0;
    end else begin
      en_q     <= en_d;
      blink_q  <= blink_d;
      bright_q <= bright_d;
      div_q    <= div_d;
      row_q    <= row_d;
    end
  end

  led_scan_timer #(
    .ROWS     (ROWS),
    .PWM_BITS (PWM_BITS),
    .DIV_W    (DIV_W),
    .ROW_W    (ROW_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_d),
    .scan_div_i  (div_q),
    .active_o    (active),
    .row_idx_o   (row_idx),
    .pwm_cnt_o   (pwm_cnt),
    .frame_cnt_o (frame_cnt),
    .frame_o     (frame_o)
  );

  // Output stage sees the current counter state and presents it one cycle later.
  always_comb begin
    lit       = active && (pwm_cnt < bright_q) && !(blink_q && frame_cnt[BLINK_BIT]);
    row_sel_d = active ? (ROWS'(1) << row_idx) : '0;
    col_d     = lit ? row_q[row_idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sel_q <= '0;
      col_q     <= '0;
    end else begin
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
    end
  end

  assign row_sel_o = row_sel_q;
  assign col_o     = col_q;

  always_comb begin
    read_data = '0;
    if (hit(addr_i, REG_CTRL)) begin
      read_data[CTRL_EN]                    = en_q;
      read_data[CTRL_BLINK]                 = blink_q;
      read_data[CTRL_BRIGHT_LSB +: PWM_BITS] = bright_q;
    end else if (hit(addr_i, REG_SCAN_DIV)) begin
      read_data[DIV_W-1:0] = div_q;
    end else if (hit(addr_i, REG_STATUS)) begin
      read_data[3:0]                        = 4'(row_idx);
      read_data[STATUS_PWM_LSB +: PWM_BITS] = pwm_cnt;
      read_data[STATUS_FRAME_LSB +: 16]     = frame_cnt;
    end
    for (int unsigned n = 0; n < ROWS; n++) begin
      if (hit(addr_i, REG_ROW_BASE + n)) read_data[COLS-1:0] = row_q[n];
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: randomized scans compared against
// an arithmetic model of tick count -> (row, pwm slot, frame).
module tb_led_matrix_scan;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int PWM_BITS  = 4;
  localparam int DIV_W     = 16;
  localparam int BLINK_BIT = 5;
  localparam int ADDR_W    = 4;
  localparam int SLOTS     = 1 << PWM_BITS;
  localparam int TPF       = SLOTS * ROWS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              we = 1'b0;
  logic [31:0]       rdata;
  logic [ROWS-1:0]   row_sel;
  logic [COLS-1:0]   col;
  logic              frame;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_model = 0;
  logic [COLS-1:0] m_rows [ROWS];

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS),
    .DIV_W(DIV_W), .BLINK_BIT(BLINK_BIT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .write_data(wdata), .write_en(we),
    .read_data(rdata), .row_sel_o(row_sel), .col_o(col), .frame_o(frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr  = ADDR_W'(a);
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  // Expected outputs k edges after the enabling write, given the frame count at enable.
  function automatic void exp_at(input int k, input int d, input int b, input bit blink,
                                 input int f0, output logic [ROWS-1:0] rs,
                                 output logic [COLS-1:0] cl, output logic fo,
                                 output logic [31:0] st);
    int per, t_now, t_out, row, pwm, fr;
    per   = d + 1;
    t_now = k / per;
    st    = (32'(f0 + t_now / TPF) << 16) | (32'(t_now % SLOTS) << 8)
          | 32'((t_now / SLOTS) % ROWS);
    rs = '0;
    cl = '0;
    fo = 1'b0;
    if (k > 0) begin
      t_out = (k - 1) / per;
      row   = (t_out / SLOTS) % ROWS;
      pwm   = t_out % SLOTS;
      fr    = f0 + t_out / TPF;
      rs    = ROWS'(1) << row;
      if (pwm < b && !(blink && (((fr >> BLINK_BIT) & 1) == 1))) cl = m_rows[row];
      fo    = (k % per == 0) && (t_now % TPF == 0);
    end
  endfunction

  task automatic load_rows(input bit nonzero);
    logic [31:0] d;
    for (int n = 0; n < ROWS; n++) begin
      m_rows[n] = COLS'($urandom) | COLS'(nonzero);
      d = $urandom;
      d[COLS-1:0] = m_rows[n];
      wr(4 + n, d);
    end
  endtask

  task automatic start_scan(input int d, input int b, input bit blink);
    wr(1, 32'(d));
    wr(0, 32'h1 | (32'(blink) << 1) | (32'(b) << 8));
    addr = 4'd2;
    #1;
    n_tests++;
    if (row_sel !== '0 || col !== '0 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_edge got row_sel=%h col=%h frame=%b want 0/0/0", row_sel, col, frame);
    end
    n_tests++;
    if (rdata !== (32'(frame_model) << 16)) begin
      n_fail++;
      $display("FAIL enable_status got %h want %h", rdata, 32'(frame_model) << 16);
    end
  endtask

  task automatic stop_scan(input int k_run, input int d);
    frame_model = (frame_model + (k_run / (d + 1)) / TPF) & 16'hffff;
    wr(0, 32'h0);
    addr = 4'd2;
    #1;
    n_tests++;
    if (row_sel !== '0 || col !== '0 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL disable got row_sel=%h col=%h frame=%b want 0/0/0", row_sel, col, frame);
    end
    n_tests++;
    if (rdata !== (32'(frame_model) << 16)) begin
      n_fail++;
      $display("FAIL disable_status got %h want %h", rdata, 32'(frame_model) << 16);
    end
  endtask

  // Runs K edges of an active scan, comparing every cycle against exp_at.
  task automatic scan_and_compare(input int K, input int d, input int b, input bit blink,
                                  input int lo, input int hi,
                                  output int lit_win, output int pulses);
    logic [ROWS-1:0] e_rs;
    logic [COLS-1:0] e_cl;
    logic            e_fo;
    logic [31:0]     e_st;
    lit_win = 0;
    pulses  = 0;
    addr    = 4'd2;
    for (int k = 1; k <= K; k++) begin
      step();
      exp_at(k, d, b, blink, frame_model, e_rs, e_cl, e_fo, e_st);
      n_tests++;
      if (row_sel !== e_rs) begin
        n_fail++;
        $display("FAIL scan_row_sel k=%0d got %h want %h", k, row_sel, e_rs);
      end
      n_tests++;
      if (col !== e_cl) begin
        n_fail++;
        $display("FAIL scan_col k=%0d got %h want %h", k, col, e_cl);
      end
      n_tests++;
      if (frame !== e_fo) begin
        n_fail++;
        $display("FAIL scan_frame k=%0d got %b want %b", k, frame, e_fo);
      end
      n_tests++;
      if (rdata !== e_st) begin
        n_fail++;
        $display("FAIL scan_status k=%0d got %h want %h", k, rdata, e_st);
      end
      if (k >= lo && k <= hi && col !== '0) lit_win++;
      if (frame === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if (row_sel !== '0 || col !== '0 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got row_sel=%h col=%h frame=%b want 0/0/0", row_sel, col, frame);
    end
    #2 rst = 1'b0;
    step();
    for (int a = 0; a < 16; a++) begin
      addr = ADDR_W'(a);
      #1;
      n_tests++;
      if (rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got %h want 0", a, rdata);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] exp_reg [16];
    logic [31:0] v;
    for (int a = 0; a < 16; a++) exp_reg[a] = 32'h0;
    v = $urandom;
    v[0] = 1'b0;
    wr(0, v);
    exp_reg[0] = v & ((32'(SLOTS - 1) << 8) | 32'h2);
    v = $urandom;
    wr(1, v);
    exp_reg[1] = v & 32'(((1 << DIV_W) - 1));
    load_rows(1'b0);
    for (int n = 0; n < ROWS; n++) exp_reg[4 + n] = 32'(m_rows[n]);
    wr(2, 32'hffff_ffff);
    wr(3, 32'hffff_ffff);
    for (int a = 4 + ROWS; a < 16; a++) wr(a, 32'hffff_ffff);
    for (int a = 0; a < 16; a++) begin
      addr = ADDR_W'(a);
      #1;
      n_tests++;
      if (rdata !== exp_reg[a]) begin
        n_fail++;
        $display("FAIL reg_read addr=%0d got %h want %h", a, rdata, exp_reg[a]);
      end
    end
    n_tests++;
    if (row_sel !== '0 || col !== '0) begin
      n_fail++;
      $display("FAIL regs_idle_outputs got row_sel=%h col=%h want 0/0", row_sel, col);
    end
  endtask

  task automatic test_scan_basic();
    int lit, pulses;
    load_rows(1'b0);
    m_rows[0] = 8'hA5;
    m_rows[1] = 8'h3C;
    wr(4, 32'hA5);
    wr(5, 32'h3C);
    start_scan(0, 15, 1'b0);
    scan_and_compare(300, 0, 15, 1'b0, 1, 16, lit, pulses);
    n_tests++;
    if (lit !== 15) begin
      n_fail++;
      $display("FAIL basic_row0_lit got %0d want 15", lit);
    end
    n_tests++;
    if (pulses !== 2) begin
      n_fail++;
      $display("FAIL basic_frame_pulses got %0d want 2", pulses);
    end
    stop_scan(300, 0);
  endtask

  task automatic test_brightness();
    int lit, pulses;
    int levels [4];
    levels[0] = 0;
    levels[1] = 4;
    levels[2] = 8;
    levels[3] = $urandom_range(1, SLOTS - 1);
    load_rows(1'b1);
    foreach (levels[i]) begin
      start_scan(3, levels[i], 1'b0);
      scan_and_compare(2 * 4 * SLOTS, 3, levels[i], 1'b0, 1, 4 * SLOTS, lit, pulses);
      n_tests++;
      if (lit !== levels[i] * 4) begin
        n_fail++;
        $display("FAIL duty b=%0d got %0d want %0d", levels[i], lit, levels[i] * 4);
      end
      stop_scan(2 * 4 * SLOTS, 3);
    end
  endtask

  task automatic test_random();
    int lit, pulses, k_run, d, b;
    bit blink;
    for (int it = 0; it < 4; it++) begin
      d     = $urandom_range(0, 3);
      b     = $urandom_range(0, SLOTS - 1);
      blink = 1'($urandom);
      k_run = $urandom_range(100, 700);
      load_rows(1'b0);
      start_scan(d, b, blink);
      scan_and_compare(k_run, d, b, blink, 0, 0, lit, pulses);
      stop_scan(k_run, d);
      start_scan(d, b, blink);
      scan_and_compare(40, d, b, blink, 0, 0, lit, pulses);
      stop_scan(40, d);
    end
  endtask

  task automatic test_blink();
    int lit, pulses;
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    frame_model = 0;
    load_rows(1'b1);
    start_scan(0, 15, 1'b1);
    scan_and_compare(96 * TPF, 0, 15, 1'b1, 32 * TPF + 1, 64 * TPF, lit, pulses);
    n_tests++;
    if (lit !== 0) begin
      n_fail++;
      $display("FAIL blink_dark_lit got %0d want 0", lit);
    end
    n_tests++;
    if (pulses !== 96) begin
      n_fail++;
      $display("FAIL blink_frame_pulses got %0d want 96", pulses);
    end
    stop_scan(96 * TPF, 0);
  endtask

  task automatic test_async_reset();
    int lit, pulses;
    load_rows(1'b1);
    start_scan(0, 15, 1'b0);
    scan_and_compare(50, 0, 15, 1'b0, 0, 0, lit, pulses);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (row_sel !== '0 || col !== '0 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got row_sel=%h col=%h frame=%b want 0/0/0", row_sel, col, frame);
    end
    addr = 4'd0;
    #1;
    n_tests++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl got %h want 0", rdata);
    end
    #2 rst = 1'b0;
    frame_model = 0;
    step();
    for (int a = 0; a < 16; a++) begin
      addr = ADDR_W'(a);
      #1;
      n_tests++;
      if (rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL post_reset_read addr=%0d got %h want 0", a, rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_scan_basic();
    test_brightness();
    test_random();
    test_blink();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
